// File: rtl/gps_sat_scheduler.sv
// Double-buffered satellite config: host writes land in shadow, commit applies the set atomically one cycle after the next epoch pulse.
// Writes take effect in shadow one cycle later; no backpressure, bad writes are dropped and flagged with wr_err.
module gps_sat_scheduler #(
   parameter int Nsat         = 4,
   parameter int EPOCH_CYCLES = 100000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_addr,
   input  logic [31:0]                wr_data,
   input  logic                       commit,
   output logic                       pending,
   output logic                       applied,
   output logic                       wr_err,
   output logic                       epoch,
   output logic [31:0]                epoch_count,
   output logic                       enable,
   output logic [Nsat-1:0][31:0]      freq,
   output logic [Nsat-1:0][15:0]      gain,
   output logic [Nsat-1:0][5:0]       ca_sel,
   output logic [15:0]                noise_gain
);

   localparam int         CW    = (EPOCH_CYCLES > 2) ? $clog2(EPOCH_CYCLES) : 1;
   localparam logic [6:0] NSAT7 = 7'(Nsat);

   typedef enum logic {IDLE, ARMED} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [31:0]           ecnt_q, ecnt_d;
   logic                  applied_q, applied_d;
   logic                  wr_err_q, wr_err_d;

   logic                  sh_en_q, sh_en_d, act_en_q, act_en_d;
   logic [15:0]           sh_ng_q, sh_ng_d, act_ng_q, act_ng_d;
   logic [Nsat-1:0][31:0] sh_fr_q, sh_fr_d, act_fr_q, act_fr_d;
   logic [Nsat-1:0][15:0] sh_gn_q, sh_gn_d, act_gn_q, act_gn_d;
   logic [Nsat-1:0][5:0]  sh_cs_q, sh_cs_d, act_cs_q, act_cs_d;

   logic [5:0]            idx;
   logic [1:0]            fld;
   logic                  sat_hit, glb_hit, wr_ok, apply, epoch_w;

   always_comb begin
      state_d   = state_q;
      sh_en_d   = sh_en_q;
      sh_ng_d   = sh_ng_q;
      sh_fr_d   = sh_fr_q;
      sh_gn_d   = sh_gn_q;
      sh_cs_d   = sh_cs_q;
      act_en_d  = act_en_q;
      act_ng_d  = act_ng_q;
      act_fr_d  = act_fr_q;
      act_gn_d  = act_gn_q;
      act_cs_d  = act_cs_q;

      epoch_w = (cnt_q == CW'(EPOCH_CYCLES - 1));
      cnt_d   = epoch_w ? '0 : cnt_q + CW'(1);
      ecnt_d  = epoch_w ? ecnt_q + 32'd1 : ecnt_q;

      idx     = wr_addr[7:2];
      fld     = wr_addr[1:0];
      sat_hit = ({1'b0, idx} < NSAT7);
      glb_hit = (idx == 6'd63);
      if (sat_hit)
         wr_ok = (fld == 2'd0) || (fld == 2'd1) || ((fld == 2'd2) && (wr_data <= 32'd35));
      else if (glb_hit)
         wr_ok = (fld <= 2'd1);
      else
         wr_ok = 1'b0;

      wr_err_d = wr_en && !wr_ok;

      if (wr_en && wr_ok) begin
         if (glb_hit) begin
            if (fld == 2'd0) sh_ng_d = wr_data[15:0];
            else             sh_en_d = wr_data[0];
         end else begin
            for (int i = 0; i < Nsat; i++) begin
               if (idx == 6'(i)) begin
                  case (fld)
                     2'd0:    sh_fr_d[i] = wr_data;
                     2'd1:    sh_gn_d[i] = wr_data[15:0];
                     default: sh_cs_d[i] = wr_data[5:0];
                  endcase
               end
            end
         end
      end

      // Apply uses the registered shadow, so a write in the apply cycle misses this set.
      apply     = (state_q == ARMED) && epoch_w;
      applied_d = apply;
      if (apply) begin
         act_en_d = sh_en_q;
         act_ng_d = sh_ng_q;
         act_fr_d = sh_fr_q;
         act_gn_d = sh_gn_q;
         act_cs_d = sh_cs_q;
      end

      case (state_q)
         IDLE:    if (commit)  state_d = ARMED;
         ARMED:   if (epoch_w) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ecnt_q    <= '0;
         applied_q <= 1'b0;
         wr_err_q  <= 1'b0;
         sh_en_q   <= 1'b0;
         sh_ng_q   <= '0;
         sh_fr_q   <= '0;
         sh_gn_q   <= '0;
         act_en_q  <= 1'b0;
         act_ng_q  <= '0;
         act_fr_q  <= '0;
         act_gn_q  <= '0;
         for (int i = 0; i < Nsat; i++) begin
            sh_cs_q[i]  <= 6'(i);
            act_cs_q[i] <= 6'(i);
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ecnt_q    <= ecnt_d;
         applied_q <= applied_d;
         wr_err_q  <= wr_err_d;
         sh_en_q   <= sh_en_d;
         sh_ng_q   <= sh_ng_d;
         sh_fr_q   <= sh_fr_d;
         sh_gn_q   <= sh_gn_d;
         sh_cs_q   <= sh_cs_d;
         act_en_q  <= act_en_d;
         act_ng_q  <= act_ng_d;
         act_fr_q  <= act_fr_d;
         act_gn_q  <= act_gn_d;
         act_cs_q  <= act_cs_d;
      end
   end

   assign pending     = (state_q == ARMED);
   assign applied     = applied_q;
   assign wr_err      = wr_err_q;
   assign epoch       = epoch_w;
   assign epoch_count = ecnt_q;
   assign enable      = act_en_q;
   assign freq        = act_fr_q;
   assign gain        = act_gn_q;
   assign ca_sel      = act_cs_q;
   assign noise_gain  = act_ng_q;

endmodule

// File: tb/tb_gps_sat_scheduler.sv
// Directed bench for gps_sat_scheduler with a queue of expected active sets checked on each applied pulse.
module tb_gps_sat_scheduler;

   logic               clk = 1'b0;
   logic               reset, wr_en, commit;
   logic [7:0]         wr_addr;
   logic [31:0]        wr_data;
   logic               pending, applied, wr_err, epoch, enable;
   logic [31:0]        epoch_count;
   logic [3:0][31:0]   freq;
   logic [3:0][15:0]   gain;
   logic [3:0][5:0]    ca_sel;
   logic [15:0]        noise_gain;

   typedef struct packed {
      logic             en;
      logic [3:0][31:0] fr;
      logic [3:0][15:0] gn;
      logic [3:0][5:0]  cs;
      logic [15:0]      ng;
   } act_t;

   act_t model, reset_set;
   act_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   applied_seen = 0;
   int   gap;

   always #5 clk = ~clk;

   gps_sat_scheduler #(.Nsat(4), .EPOCH_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .pending(pending), .applied(applied), .wr_err(wr_err),
      .epoch(epoch), .epoch_count(epoch_count), .enable(enable), .freq(freq),
      .gain(gain), .ca_sel(ca_sel), .noise_gain(noise_gain)
   );

   task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
      n_checks++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
      end
   endtask

   function automatic act_t obs();
      act_t a;
      a.en = enable;
      a.fr = freq;
      a.gn = gain;
      a.cs = ca_sel;
      a.ng = noise_gain;
      return a;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_epoch(output int n);
      n = 0;
      for (int k = 0; k < 25; k++) begin
         step();
         n++;
         if (epoch) return;
      end
      chk("epoch_timeout", n, 0);
   endtask

   task automatic write(input logic [5:0] idx, input logic [1:0] fld, input logic [31:0] d,
                        input logic exp_err);
      wr_en   = 1'b1;
      wr_addr = {idx, fld};
      wr_data = d;
      step();
      wr_en   = 1'b0;
      commit  = 1'b0;
      chk("wr_err", wr_err, exp_err);
      if (!exp_err) begin
         if (idx == 6'd63) begin
            if (fld == 2'd0) model.ng = d[15:0];
            else             model.en = d[0];
         end else begin
            case (fld)
               2'd0:    model.fr[idx[1:0]] = d;
               2'd1:    model.gn[idx[1:0]] = d[15:0];
               default: model.cs[idx[1:0]] = d[5:0];
            endcase
         end
      end
   endtask

   task automatic do_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
      sb.push_back(model);
      chk("pending_after_commit", pending, 1'b1);
   endtask

   always @(posedge clk) begin
      #1;
      if (applied) begin
         applied_seen++;
         if (sb.size() == 0) chk("apply_unexpected_q", sb.size(), 1);
         else                chk("apply_set", obs(), sb.pop_front());
      end
   end

   initial begin
      reset_set    = '0;
      reset_set.cs = {6'd3, 6'd2, 6'd1, 6'd0};
      model        = reset_set;
      reset = 1'b1; wr_en = 1'b0; commit = 1'b0; wr_addr = '0; wr_data = '0;
      step(); step();
      chk("rst_active", obs(), reset_set);
      chk("rst_pending", pending, 1'b0);
      chk("rst_applied", applied, 1'b0);
      chk("rst_wr_err", wr_err, 1'b0);
      chk("rst_epoch", epoch, 1'b0);
      chk("rst_epoch_count", epoch_count, 32'd0);

      // Two idle epochs: pulse on counts 9 and 19 after release
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("epoch_pulse", epoch, (k % 10) == 9);
      end
      chk("epoch_count_2", epoch_count, 32'd2);
      chk("idle_ca_sel", ca_sel, reset_set.cs);
      chk("idle_enable", enable, 1'b0);

      // Basic write / commit / apply
      write(6'd0, 2'd0, 32'h028F5C29, 1'b0);
      write(6'd0, 2'd1, 32'h0000FFFF, 1'b0);
      write(6'd63, 2'd0, 32'h00004000, 1'b0);
      write(6'd63, 2'd1, 32'h00000001, 1'b0);
      chk("no_early_apply", enable, 1'b0);
      do_commit();
      wait_epoch(gap);
      chk("pending_at_epoch", pending, 1'b1);
      chk("freq_before_apply", freq[0], 32'd0);
      step();
      chk("applied_pulse", applied, 1'b1);
      chk("pending_clear", pending, 1'b0);
      chk("freq0_applied", freq[0], 32'h028F5C29);
      chk("enable_applied", enable, 1'b1);
      step();
      chk("applied_one_shot", applied, 1'b0);

      // Commit coincident with epoch arms for the following epoch
      write(6'd0, 2'd0, 32'h11111111, 1'b0);
      wait_epoch(gap);
      commit = 1'b1;
      step();
      commit = 1'b0;
      sb.push_back(model);
      chk("arm_on_epoch", pending, 1'b1);
      chk("no_same_cycle_apply", applied, 1'b0);
      chk("freq_held", freq[0], 32'h028F5C29);
      wait_epoch(gap);
      chk("epoch_gap", gap, 9);
      chk("freq_held_late", freq[0], 32'h028F5C29);
      step();
      chk("late_applied", applied, 1'b1);
      chk("late_freq", freq[0], 32'h11111111);

      // Rejected writes and ca_sel boundary
      write(6'd1, 2'd2, 32'd40, 1'b1);
      write(6'd5, 2'd0, 32'hABCD0000, 1'b1);
      write(6'd63, 2'd2, 32'd7, 1'b1);
      write(6'd0, 2'd3, 32'd9, 1'b1);
      write(6'd2, 2'd2, 32'd35, 1'b0);
      do_commit();
      wait_epoch(gap);
      step();
      chk("ca1_unchanged", ca_sel[1], 6'd1);
      chk("ca2_boundary", ca_sel[2], 6'd35);

      // Write and commit in the apply cycle
      do_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
      chk("commit_while_armed", pending, 1'b1);
      wait_epoch(gap);
      commit = 1'b1;
      write(6'd2, 2'd1, 32'h00001234, 1'b0);
      chk("apply_cycle_applied", applied, 1'b1);
      chk("gain2_old", gain[2], 16'h0000);
      chk("no_rearm", pending, 1'b0);
      step();
      chk("no_rearm_later", pending, 1'b0);
      do_commit();
      wait_epoch(gap);
      step();
      chk("gain2_new", gain[2], 16'h1234);

      // Reset while armed discards the commit and the shadow
      write(6'd1, 2'd0, 32'hDEAD0001, 1'b0);
      commit = 1'b1;
      step();
      commit = 1'b0;
      chk("armed_before_reset", pending, 1'b1);
      step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      model = reset_set;
      chk("mid_rst_active", obs(), reset_set);
      chk("mid_rst_pending", pending, 1'b0);
      chk("mid_rst_epoch_count", epoch_count, 32'd0);
      chk("mid_rst_applied", applied, 1'b0);
      for (int k = 0; k < 25; k++) begin
         step();
         chk("post_rst_pending", pending, 1'b0);
         chk("post_rst_freq1", freq[1], 32'd0);
      end
      do_commit();
      wait_epoch(gap);
      step();
      chk("shadow_was_reset", enable, 1'b0);

      step();
      chk("queue_drained", sb.size(), 0);
      chk("apply_count", applied_seen, 6);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
